// File: rtl/axi_warb_pkg.sv
// Shared types for the two-master AXI write arbiter: FSM states, master index, ID tag width
// and the BRESP encodings.
package axi_warb_pkg;

  localparam int TAG_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    RESP = 2'd3
  } state_t;

  typedef enum logic {
    M0 = 1'b0,
    M1 = 1'b1
  } mst_t;

  localparam logic [1:0] BRESP_OKAY   = 2'b00;
  localparam logic [1:0] BRESP_SLVERR = 2'b10;

endpackage

// File: rtl/axi_warb_if.sv
// AXI4 write-channel bundle (AW/W/B). The master modport issues writes; the slave modport
// accepts them.
interface axi_warb_if #(
  parameter int ID_W = 4
);
  logic [ID_W-1:0] AWID;
  logic [31:0]     AWADDR;
  logic [3:0]      AWLEN;
  logic [2:0]      AWSIZE;
  logic [1:0]      AWBURST;
  logic            AWVALID;
  logic            AWREADY;

  logic [31:0]     WDATA;
  logic [3:0]      WSTRB;
  logic            WLAST;
  logic            WVALID;
  logic            WREADY;

  logic [ID_W-1:0] BID;
  logic [1:0]      BRESP;
  logic            BVALID;
  logic            BREADY;

  modport master (
    output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
    input  AWREADY,
    output WDATA, WSTRB, WLAST, WVALID,
    input  WREADY,
    input  BID, BRESP, BVALID,
    output BREADY
  );

  modport slave (
    input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
    output AWREADY,
    input  WDATA, WSTRB, WLAST, WVALID,
    output WREADY,
    output BID, BRESP, BVALID,
    input  BREADY
  );

endinterface

// File: rtl/axi_warb_rr.sv
// Two-way round-robin picker, purely combinational: a lone requester wins, on a tie the
// master that did not win last time wins.
module axi_warb_rr
  import axi_warb_pkg::*;
(
  input  logic [1:0] req,
  input  mst_t       last,
  output mst_t       gnt
);

  always_comb begin
    gnt = M0;
    if (req == 2'b11) begin
      gnt = (last == M0) ? M1 : M0;
    end else if (req[1]) begin
      gnt = M1;
    end
  end

endmodule

// File: rtl/axi_write_arbiter.sv
// Shares one AXI write path between two masters; one transaction in flight from AW grant to B.
// Optional AXI_WARB_LEN_CHECK_EN: WLAST is generated from the latched AWLEN and mismatches set len_err.
module axi_write_arbiter
  import axi_warb_pkg::*;
#(
  parameter int ID_W = 4
) (
  input  logic        clk,
  input  logic        rst,
  axi_warb_if.slave   m0,
  axi_warb_if.slave   m1,
  axi_warb_if.master  s,
  output logic        len_err
);

  state_t r_state;
  mst_t   r_grant;
  mst_t   r_last_grant;
  mst_t   w_pick;

  logic w_g1;
  logic w_in_addr, w_in_data, w_in_resp;
  logic w_aw_hs, w_w_hs, w_b_hs;

  logic [ID_W-1:0] w_awid;
  logic            w_awvalid;
  logic            w_wlast;
  logic            w_wvalid;
  logic            w_bready;
  logic [TAG_W-1:0] w_unused_bid_tag;

  axi_warb_rr u_rr (
    .req  ({m1.AWVALID, m0.AWVALID}),
    .last (r_last_grant),
    .gnt  (w_pick)
  );

  assign w_g1      = (r_grant == M1);
  assign w_in_addr = (r_state == ADDR);
  assign w_in_data = (r_state == DATA);
  assign w_in_resp = (r_state == RESP);

  assign w_awid    = w_g1 ? m1.AWID    : m0.AWID;
  assign w_awvalid = w_g1 ? m1.AWVALID : m0.AWVALID;
  assign w_wlast   = w_g1 ? m1.WLAST   : m0.WLAST;
  assign w_wvalid  = w_g1 ? m1.WVALID  : m0.WVALID;
  assign w_bready  = w_g1 ? m1.BREADY  : m0.BREADY;

  // Downstream ID carries the owning master in its upper tag bits.
  assign s.AWID    = {{(TAG_W-1){1'b0}}, r_grant, w_awid};
  assign s.AWADDR  = w_g1 ? m1.AWADDR  : m0.AWADDR;
  assign s.AWLEN   = w_g1 ? m1.AWLEN   : m0.AWLEN;
  assign s.AWSIZE  = w_g1 ? m1.AWSIZE  : m0.AWSIZE;
  assign s.AWBURST = w_g1 ? m1.AWBURST : m0.AWBURST;
  assign s.AWVALID = w_in_addr & w_awvalid;

  assign s.WDATA   = w_g1 ? m1.WDATA : m0.WDATA;
  assign s.WSTRB   = w_g1 ? m1.WSTRB : m0.WSTRB;
  assign s.WVALID  = w_in_data & w_wvalid;
  assign s.BREADY  = w_in_resp & w_bready;

  assign m0.AWREADY = w_in_addr & ~w_g1 & s.AWREADY;
  assign m1.AWREADY = w_in_addr &  w_g1 & s.AWREADY;
  assign m0.WREADY  = w_in_data & ~w_g1 & s.WREADY;
  assign m1.WREADY  = w_in_data &  w_g1 & s.WREADY;
  assign m0.BVALID  = w_in_resp & ~w_g1 & s.BVALID;
  assign m1.BVALID  = w_in_resp &  w_g1 & s.BVALID;
  assign m0.BID     = s.BID[ID_W-1:0];
  assign m1.BID     = s.BID[ID_W-1:0];
  assign m0.BRESP   = s.BRESP;
  assign m1.BRESP   = s.BRESP;

  assign w_unused_bid_tag = s.BID[ID_W+TAG_W-1:ID_W];

  assign w_aw_hs = s.AWVALID & s.AWREADY;
  assign w_w_hs  = s.WVALID & s.WREADY;
  assign w_b_hs  = s.BVALID & s.BREADY;

`ifdef AXI_WARB_LEN_CHECK_EN
  logic [3:0] r_len;
  logic [3:0] r_beat;
  logic       r_len_err;

  assign s.WLAST = (r_beat == r_len);
  assign len_err = r_len_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_len     <= 4'd0;
      r_beat    <= 4'd0;
      r_len_err <= 1'b0;
    end else if (w_aw_hs) begin
      r_len  <= s.AWLEN;
      r_beat <= 4'd0;
    end else if (w_w_hs) begin
      r_beat <= r_beat + 4'd1;
      if (w_wlast != s.WLAST) begin
        r_len_err <= 1'b1;
      end
    end
  end
`else
  assign s.WLAST = w_wlast;
  assign len_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_grant      <= M0;
      r_last_grant <= M1;
    end else begin
      case (r_state)
        IDLE: begin
          if (m0.AWVALID | m1.AWVALID) begin
            r_grant <= w_pick;
            r_state <= ADDR;
          end
        end
        ADDR: begin
          if (w_aw_hs) r_state <= DATA;
        end
        DATA: begin
          if (w_w_hs & s.WLAST) r_state <= RESP;
        end
        RESP: begin
          if (w_b_hs) begin
            r_last_grant <= r_grant;
            r_state      <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_write_arbiter.sv
// Bench for axi_write_arbiter: master/slave stimulus processes, expected-value queues checked
// by a monitor, a table of single-master writes plus hand-written arbitration and reset sequences.
module tb_axi_write_arbiter;

  localparam int BUDGET = 200;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic len_err;
  int   checks   = 0;
  int   failures = 0;

  axi_warb_if #(.ID_W(4)) m0_if ();
  axi_warb_if #(.ID_W(4)) m1_if ();
  axi_warb_if #(.ID_W(8)) s_if ();

  axi_write_arbiter #(.ID_W(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .m0      (m0_if),
    .m1      (m1_if),
    .s       (s_if),
    .len_err (len_err)
  );

  // Master-side drive and observe arrays, indexed by master number.
  logic [3:0]  mv_awid    [2];
  logic [31:0] mv_awaddr  [2];
  logic [3:0]  mv_awlen   [2];
  logic [2:0]  mv_awsize  [2];
  logic [1:0]  mv_awburst [2];
  logic        mv_awvalid [2];
  logic [31:0] mv_wdata   [2];
  logic [3:0]  mv_wstrb   [2];
  logic        mv_wlast   [2];
  logic        mv_wvalid  [2];
  logic        mv_bready  [2];
  logic        mr_awready [2];
  logic        mr_wready  [2];
  logic        mr_bvalid  [2];
  logic [3:0]  mr_bid     [2];
  logic [1:0]  mr_bresp   [2];
  logic        m_busy     [2];

  assign m0_if.AWID = mv_awid[0];       assign m1_if.AWID = mv_awid[1];
  assign m0_if.AWADDR = mv_awaddr[0];   assign m1_if.AWADDR = mv_awaddr[1];
  assign m0_if.AWLEN = mv_awlen[0];     assign m1_if.AWLEN = mv_awlen[1];
  assign m0_if.AWSIZE = mv_awsize[0];   assign m1_if.AWSIZE = mv_awsize[1];
  assign m0_if.AWBURST = mv_awburst[0]; assign m1_if.AWBURST = mv_awburst[1];
  assign m0_if.AWVALID = mv_awvalid[0]; assign m1_if.AWVALID = mv_awvalid[1];
  assign m0_if.WDATA = mv_wdata[0];     assign m1_if.WDATA = mv_wdata[1];
  assign m0_if.WSTRB = mv_wstrb[0];     assign m1_if.WSTRB = mv_wstrb[1];
  assign m0_if.WLAST = mv_wlast[0];     assign m1_if.WLAST = mv_wlast[1];
  assign m0_if.WVALID = mv_wvalid[0];   assign m1_if.WVALID = mv_wvalid[1];
  assign m0_if.BREADY = mv_bready[0];   assign m1_if.BREADY = mv_bready[1];
  assign mr_awready[0] = m0_if.AWREADY; assign mr_awready[1] = m1_if.AWREADY;
  assign mr_wready[0] = m0_if.WREADY;   assign mr_wready[1] = m1_if.WREADY;
  assign mr_bvalid[0] = m0_if.BVALID;   assign mr_bvalid[1] = m1_if.BVALID;
  assign mr_bid[0] = m0_if.BID;         assign mr_bid[1] = m1_if.BID;
  assign mr_bresp[0] = m0_if.BRESP;     assign mr_bresp[1] = m1_if.BRESP;

  // Expected-value queues per master: AW {AWID,ADDR,LEN,SIZE,BURST}, W {DATA,STRB,LAST}, B {BID,BRESP}.
  logic [48:0] awq0[$], awq1[$];
  logic [36:0] wq0[$],  wq1[$];
  logic [5:0]  bq0[$],  bq1[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic miss(input string name);
    checks++;
    failures++;
    $display("FAIL %s: DUT produced a transfer with no expected entry pending", name);
  endtask

  task automatic master_write(input int m, input logic [3:0] id, input logic [31:0] addr,
                              input logic [3:0] len, input logic [31:0] d0, input int bhold,
                              input bit early_last, output int cyc);
    int   k;
    logic wl, exp_last;
    logic [3:0] strb;
    m_busy[m] = 1'b1;
    cyc = 1;
    mv_awid[m] = id; mv_awaddr[m] = addr; mv_awlen[m] = len;
    mv_awsize[m] = 3'(2 - m); mv_awburst[m] = 2'(1 + m); mv_awvalid[m] = 1'b1;
    if (m == 0) awq0.push_back({4'(m), id, addr, len, 3'(2 - m), 2'(1 + m)});
    else        awq1.push_back({4'(m), id, addr, len, 3'(2 - m), 2'(1 + m)});
    k = 0; #1;
    while (!mr_awready[m] && k < BUDGET) begin @(negedge clk); cyc++; #1; k++; end
    chk($sformatf("awready_m%0d", m), mr_awready[m], 1'b1);
    @(negedge clk); cyc++;
    mv_awvalid[m] = 1'b0;
    for (int b = 0; b <= int'(len); b++) begin
      wl = (b == int'(len)) || (early_last && b == 0);
`ifdef AXI_WARB_LEN_CHECK_EN
      exp_last = (b == int'(len));
`else
      exp_last = wl;
`endif
      strb = 4'hF ^ 4'(b);
      mv_wdata[m] = d0 + 32'(b); mv_wstrb[m] = strb; mv_wlast[m] = wl; mv_wvalid[m] = 1'b1;
      if (m == 0) wq0.push_back({d0 + 32'(b), strb, exp_last});
      else        wq1.push_back({d0 + 32'(b), strb, exp_last});
      k = 0; #1;
      while (!mr_wready[m] && k < BUDGET) begin @(negedge clk); cyc++; #1; k++; end
      chk($sformatf("wready_m%0d_beat%0d", m, b), mr_wready[m], 1'b1);
      @(negedge clk); cyc++;
    end
    mv_wvalid[m] = 1'b0; mv_wlast[m] = 1'b0;
    repeat (bhold) begin @(negedge clk); cyc++; end
    mv_bready[m] = 1'b1;
    k = 0; #1;
    while (!mr_bvalid[m] && k < BUDGET) begin @(negedge clk); cyc++; #1; k++; end
    chk($sformatf("bvalid_m%0d", m), mr_bvalid[m], 1'b1);
    @(negedge clk);
    mv_bready[m] = 1'b0;
    m_busy[m] = 1'b0;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_awvalid_s"}, s_if.AWVALID, 0);
    chk({tag, "_wvalid_s"},  s_if.WVALID, 0);
    chk({tag, "_bready_s"},  s_if.BREADY, 0);
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("%s_awready_m%0d", tag, m), mr_awready[m], 0);
      chk($sformatf("%s_wready_m%0d", tag, m),  mr_wready[m], 0);
      chk($sformatf("%s_bvalid_m%0d", tag, m),  mr_bvalid[m], 0);
    end
    chk({tag, "_len_err"}, len_err, 0);
  endtask

  // Downstream slave: AWREADY always high, optional WREADY stall on one beat, B one cycle after WLAST.
  int         st_beat = -1;
  int         st_left = 0;
  logic [7:0] sv_awid = 8'h0;
  int         sv_beats = 0;
  bit         sv_in_data = 0, b_pend = 0, b_act = 0;
  int         b_cnt = 0;

  initial begin
    s_if.AWREADY = 1'b1; s_if.WREADY = 1'b1;
    s_if.BVALID = 1'b0; s_if.BID = 8'h0; s_if.BRESP = 2'b00;
    forever begin
      @(negedge clk);
      if (b_pend) begin
        b_pend = 0; b_act = 1;
        s_if.BVALID = 1'b1; s_if.BID = sv_awid;
        s_if.BRESP = b_cnt[0] ? 2'b10 : 2'b00;
        b_cnt++;
        if (sv_awid[7:4] == 4'd1) bq1.push_back({sv_awid[3:0], s_if.BRESP});
        else                      bq0.push_back({sv_awid[3:0], s_if.BRESP});
      end else if (!b_act) begin
        s_if.BVALID = 1'b0;
      end
      if (sv_in_data && st_left > 0 && sv_beats == st_beat) begin
        s_if.WREADY = 1'b0; st_left--;
      end else begin
        s_if.WREADY = 1'b1;
      end
      #1;
      if (s_if.AWVALID && s_if.AWREADY) begin sv_awid = s_if.AWID; sv_beats = 0; sv_in_data = 1; end
      if (s_if.WVALID && s_if.WREADY) begin
        sv_beats++;
        if (s_if.WLAST) begin b_pend = 1; sv_in_data = 0; end
      end
      if (b_act && s_if.BREADY) b_act = 0;
    end
  end

  // Monitor: pops expected transfers as handshakes occur and checks master isolation.
  int cur_m = 0;
  initial begin
    logic a0, a1;
    forever begin
      @(negedge clk);
      #2;
      if (s_if.AWVALID && s_if.AWREADY) begin
        cur_m = (s_if.AWID[7:4] == 4'd1) ? 1 : 0;
        if (cur_m == 0 && awq0.size() != 0) chk("aw_m0", {s_if.AWID, s_if.AWADDR, s_if.AWLEN, s_if.AWSIZE, s_if.AWBURST}, awq0.pop_front());
        else if (cur_m == 1 && awq1.size() != 0) chk("aw_m1", {s_if.AWID, s_if.AWADDR, s_if.AWLEN, s_if.AWSIZE, s_if.AWBURST}, awq1.pop_front());
        else miss("aw_unexpected");
      end
      if (s_if.WVALID && s_if.WREADY) begin
        if (cur_m == 0 && wq0.size() != 0) chk("w_m0", {s_if.WDATA, s_if.WSTRB, s_if.WLAST}, wq0.pop_front());
        else if (cur_m == 1 && wq1.size() != 0) chk("w_m1", {s_if.WDATA, s_if.WSTRB, s_if.WLAST}, wq1.pop_front());
        else miss("w_unexpected");
      end
      for (int m = 0; m < 2; m++) begin
        if (mr_bvalid[m] && mv_bready[m]) begin
          if (m == 0 && bq0.size() != 0) chk("b_m0", {mr_bid[0], mr_bresp[0]}, bq0.pop_front());
          else if (m == 1 && bq1.size() != 0) chk("b_m1", {mr_bid[1], mr_bresp[1]}, bq1.pop_front());
          else miss($sformatf("b_unexpected_m%0d", m));
        end
      end
      if (s_if.BVALID) chk("bready_s_follows_owner", s_if.BREADY, mv_bready[0] | mv_bready[1]);
      a0 = mr_awready[0] | mr_wready[0] | mr_bvalid[0];
      a1 = mr_awready[1] | mr_wready[1] | mr_bvalid[1];
      if (a0 || a1) begin
        chk("masters_exclusive", a0 & a1, 0);
        chk("idle_m0_quiet", a0 & !m_busy[0], 0);
        chk("idle_m1_quiet", a1 & !m_busy[1], 0);
      end
    end
  end

  typedef struct {
    int          m;
    logic [3:0]  id;
    logic [31:0] addr;
    logic [3:0]  len;
    logic [31:0] data;
    int          stall_beat;
    int          stall_cyc;
    int          bhold;
    int          exp_cyc;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int c0, c1, c;
    vecs[0] = '{0, 4'h5, 32'h0000_1000, 4'd0,  32'hDEAD_BEEF, -1, 0, 0, 4};
    vecs[1] = '{1, 4'hA, 32'h0000_2000, 4'd3,  32'h1111_0000,  2, 2, 0, 9};
    vecs[2] = '{1, 4'h3, 32'h0000_2040, 4'd1,  32'hA5A5_0000, -1, 0, 3, 8};
    vecs[3] = '{0, 4'hF, 32'hFFFF_FFC0, 4'd15, 32'h0000_0100, -1, 0, 0, 19};
    vecs[4] = '{0, 4'h0, 32'h0000_0040, 4'd2,  32'h1234_5678,  0, 1, 1, 8};

    for (int m = 0; m < 2; m++) begin
      mv_awid[m] = '0; mv_awaddr[m] = '0; mv_awlen[m] = '0; mv_awsize[m] = '0;
      mv_awburst[m] = '0; mv_awvalid[m] = 1'b0; mv_wdata[m] = '0; mv_wstrb[m] = '0;
      mv_wlast[m] = 1'b0; mv_wvalid[m] = 1'b0; mv_bready[m] = 1'b0; m_busy[m] = 1'b0;
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1 chk_quiet("in_reset");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1 chk_quiet("after_reset");
    @(negedge clk);

    // Simultaneous requests: M0 wins first after reset and again after M1 was served.
    for (int r = 0; r < 2; r++) begin
      fork
        master_write(0, 4'h1, 32'h0000_0100 + 32'(r), 4'd0, 32'hC0DE_0000 + 32'(r), 0, 1'b0, c0);
        master_write(1, 4'h2, 32'h0000_0200 + 32'(r), 4'd0, 32'hBEEF_0000 + 32'(r), 0, 1'b0, c1);
      join
      chk($sformatf("tie%0d_m0_cycles", r), c0, 4);
      chk($sformatf("tie%0d_m1_cycles", r), c1, 8);
    end

    for (int i = 0; i < 5; i++) begin
      st_beat = vecs[i].stall_beat;
      st_left = vecs[i].stall_cyc;
      master_write(vecs[i].m, vecs[i].id, vecs[i].addr, vecs[i].len, vecs[i].data,
                   vecs[i].bhold, 1'b0, c);
      chk($sformatf("vec%0d_cycles", i), c, vecs[i].exp_cyc);
    end
    st_beat = -1; st_left = 0;

    // M0 was served last, so a tie now goes to M1.
    fork
      master_write(0, 4'h7, 32'h0000_0300, 4'd0, 32'h0000_0007, 0, 1'b0, c0);
      master_write(1, 4'h8, 32'h0000_0400, 4'd0, 32'h0000_0008, 0, 1'b0, c1);
    join
    chk("tie_after_m0_m1_cycles", c1, 4);
    chk("tie_after_m0_m0_cycles", c0, 8);

    // M1 holds off BREADY for 3 cycles; M0 arrives mid-transaction and must wait for the B handshake.
    fork
      master_write(1, 4'h9, 32'h0000_0500, 4'd0, 32'h0000_0009, 3, 1'b0, c1);
      begin
        repeat (2) @(negedge clk);
        master_write(0, 4'h4, 32'h0000_0600, 4'd0, 32'h0000_0004, 0, 1'b0, c0);
      end
    join
    chk("bhold_m1_cycles", c1, 7);
    chk("bhold_m0_waits_cycles", c0, 9);

    // Reset during beat 2 of a 4-beat M0 burst.
    m_busy[0] = 1'b1;
    mv_awid[0] = 4'h6; mv_awaddr[0] = 32'h0000_3000; mv_awlen[0] = 4'd3;
    mv_awsize[0] = 3'd2; mv_awburst[0] = 2'd1; mv_awvalid[0] = 1'b1;
    awq0.push_back({4'h0, 4'h6, 32'h0000_3000, 4'd3, 3'd2, 2'd1});
    begin
      int k;
      k = 0; #1;
      while (!mr_awready[0] && k < BUDGET) begin @(negedge clk); #1; k++; end
      chk("rst_seq_awready", mr_awready[0], 1'b1);
      @(negedge clk);
      mv_awvalid[0] = 1'b0;
      for (int b = 0; b < 3; b++) begin
        mv_wdata[0] = 32'h5500_0000 + 32'(b); mv_wstrb[0] = 4'hF; mv_wlast[0] = 1'b0; mv_wvalid[0] = 1'b1;
        wq0.push_back({32'h5500_0000 + 32'(b), 4'hF, 1'b0});
        if (b == 2) rst = 1'b1;
        k = 0; #1;
        while (!mr_wready[0] && k < BUDGET) begin @(negedge clk); #1; k++; end
        chk($sformatf("rst_seq_wready_beat%0d", b), mr_wready[0], 1'b1);
        @(negedge clk);
      end
    end
    rst = 1'b0;
    mv_wvalid[0] = 1'b0;
    m_busy[0] = 1'b0;
    #1 chk_quiet("after_mid_rst");
    @(negedge clk);
    master_write(0, 4'hC, 32'h0000_1000, 4'd0, 32'hDEAD_BEEF, 0, 1'b0, c);
    chk("post_rst_m0_cycles", c, 4);

`ifdef AXI_WARB_LEN_CHECK_EN
    chk("len_err_before", len_err, 0);
    master_write(0, 4'hD, 32'h0000_7000, 4'd1, 32'h7700_0000, 0, 1'b1, c);
    chk("len_err_cycles", c, 5);
    chk("len_err_set", len_err, 1);
    master_write(1, 4'hE, 32'h0000_7100, 4'd0, 32'h7800_0000, 0, 1'b0, c);
    chk("len_err_sticky", len_err, 1);
`else
    chk("len_err_tied_low", len_err, 0);
`endif

    repeat (2) @(negedge clk);
    chk("awq0_drained", awq0.size(), 0);
    chk("awq1_drained", awq1.size(), 0);
    chk("wq0_drained", wq0.size(), 0);
    chk("wq1_drained", wq1.size(), 0);
    chk("bq0_drained", bq0.size(), 0);
    chk("bq1_drained", bq1.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/axi_write_arbiter.md
# axi_write_arbiter

Two-master AXI4 write-channel arbiter that shares one downstream write path (AW/W/B) between M0 and M1. Sits in the AXI bridge upstream of the write-address decoder and write-data router. Grants the path by round robin and holds it from AW handshake through B handshake, so at most one write transaction is in flight. Widens AWID with a master tag and returns B responses to the owning master.

## Interface
- `ID_W`, default 4: master-side ID width; downstream ID width is `ID_W+4`.
- `clk` in 1: single clock, all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `AWID_M{0,1}` in `ID_W`, `AWADDR_M{0,1}` in 32, `AWLEN_M{0,1}` in 4, `AWSIZE_M{0,1}` in 3, `AWBURST_M{0,1}` in 2, `AWVALID_M{0,1}` in 1: master write-address channels.
- `AWREADY_M{0,1}` out 1: address accept per master.
- `WDATA_M{0,1}` in 32, `WSTRB_M{0,1}` in 4, `WLAST_M{0,1}` in 1, `WVALID_M{0,1}` in 1: master write-data channels.
- `WREADY_M{0,1}` out 1: data accept per master.
- `BID_M{0,1}` out `ID_W`, `BRESP_M{0,1}` out 2, `BVALID_M{0,1}` out 1: responses to masters.
- `BREADY_M{0,1}` in 1: master response accept.
- `AWID_S` out `ID_W+4`, `AWADDR_S` out 32, `AWLEN_S` out 4, `AWSIZE_S` out 3, `AWBURST_S` out 2, `AWVALID_S` out 1, `AWREADY_S` in 1: downstream AW.
- `WDATA_S` out 32, `WSTRB_S` out 4, `WLAST_S` out 1, `WVALID_S` out 1, `WREADY_S` in 1: downstream W.
- `BID_S` in `ID_W+4`, `BRESP_S` in 2, `BVALID_S` in 1, `BREADY_S` out 1: downstream B.
- `len_err` out 1: sticky burst-length mismatch flag (see Configuration).

## Operation
- FSM states: IDLE, ADDR, DATA, RESP. Registered `grant` (M0/M1) and `last_grant`.
- IDLE: if any `AWVALID_Mx`, the round-robin picker selects a master and registers `grant`; next state is ADDR. Only one requester: it wins. Both requesting: the master that is not `last_grant` wins.
- ADDR: downstream AW carries the granted master's fields. `AWID_S = {4'(grant), AWID_Mg}`. `AWREADY_Mg = AWREADY_S`. On `AWVALID_S & AWREADY_S`, latch `AWLEN` and clear the beat counter; next state is DATA.
- DATA: downstream W is muxed from the granted master. `WREADY_Mg = WREADY_S`. Each W handshake increments `beat` (4-bit). On a handshake with `WLAST_S`, next state is RESP.
- RESP: `BVALID_Mg = BVALID_S`. `BID_Mg = BID_S[ID_W-1:0]`. `BRESP_Mg = BRESP_S`. `BREADY_S = BREADY_Mg`. On the B handshake, `last_grant <= grant`; next state is IDLE.
- The non-granted master sees all READY and all VALID at 0. In IDLE, all downstream VALID and READY outputs are 0.
- Dropping a master AWVALID before its handshake violates the protocol and is unsupported.

## Timing
- Reset: state IDLE, `last_grant=M1` (so M0 wins first), beat counter 0, `len_err` 0.
- All VALID/READY outputs are 0 during reset and in the cycle after reset.
- AW latency: `AWVALID_S` rises 1 cycle after master `AWVALID` is first seen in IDLE.
- W and B paths are combinational pass-through in DATA and RESP respectively (0 added latency per beat).
- Minimum transaction length: 1 (IDLE) + 1 (ADDR) + LEN+1 (DATA) + 1 (RESP) cycles.
- Back-to-back: the next grant decision is made in the IDLE cycle after the B handshake.
- A request arriving during a busy transaction waits; nothing is queued beyond the masters' own VALID hold.
- `rst` mid-transaction returns to IDLE immediately. Downstream VALIDs are 0 in the next cycle and the in-flight burst is abandoned.

## Configuration
- `AXI_WARB_LEN_CHECK_EN` defined:
  - `WLAST_S` is generated from the counter as `beat == latched AWLEN`, and the master's WLAST is ignored for termination.
  - If the master's WLAST differs from the generated value on any beat, `len_err` is set; it clears only on reset.
- Not defined:
  - `WLAST_S = WLAST_Mg`, and DATA exits on the master's WLAST.
  - `len_err` is tied to 0 and the beat counter is not instantiated.

## Structure
- Package `axi_warb_pkg`: state enum (IDLE/ADDR/DATA/RESP), master index type, `TAG_W = 4`, BRESP constants (OKAY=2'b00, SLVERR=2'b10).
- Sub-module `axi_warb_rr`: 2-way round-robin picker, combinational. Inputs `req[1:0]` and `last`; output `gnt`.

## Test plan
- Single M0 write, AWADDR=0x1000, LEN=0, data 0xDEADBEEF -> `AWID_S={4'h0,id}`, one W beat forwarded, B returned to M0 only, FSM back in IDLE after 4 cycles minimum.
- M0 and M1 assert AWVALID in the same cycle after reset -> M0 served first, then M1. Repeat simultaneous requests -> grants alternate M0, M1, M0, M1.
- M1 burst LEN=3 with `WREADY_S` stalled 2 cycles on beat 2 -> 4 beats in order, no beat dropped or duplicated, `WREADY_M0` stays 0 throughout.
- `BVALID_S` held with `BREADY_M1=0` for 3 cycles -> `BREADY_S=0`, and a pending M0 request is not granted until the B handshake.
- With `AXI_WARB_LEN_CHECK_EN`, LEN=1 and master WLAST asserted on beat 0 -> `len_err=1`, `WLAST_S` on beat 1 only.
- `rst` pulsed during DATA beat 2 of LEN=3 -> next cycle all VALIDs are 0 and state is IDLE; a new M0 request completes normally.
